// File: rtl/readout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : readout_pkg
// Description : Shared types and constants for the channel-buffer readout
//               sequencer: FSM state encoding, readout mode encoding and a
//               helper that sizes the channel-select field.
// Revision    : 1.0 - initial release
// ============================================================================
package readout_pkg;

  // Transaction state: IDLE while SPI slave select is high, ACTIVE while low.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Readout modes, latched at the start of each transaction.
  localparam logic MODE_SINGLE = 1'b0;  // one channel, walk the addresses
  localparam logic MODE_RR     = 1'b1;  // all channels at each address

  // Channel-select width; a single-channel build still needs a 1-bit port.
  function automatic int chan_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/readout_addr_counter.sv
`default_nettype none
// ============================================================================
// Module      : readout_addr_counter
// Description : Read-address / channel counter for the readout sequencer.
//               Steps the channel (round-robin) and/or the address on each
//               accepted word, wraps at the programmable last address and
//               flags the frame wrap.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               clear          - force address and channel to 0
//               load           - start of transaction: address 0, channel
//                                load_chan
//               advance        - current word consumed, step the counters
//               round_robin    - step channels before addresses
//               load_chan      - channel loaded at transaction start
//               home_chan      - channel returned to on each address step
//               last_addr      - last address of the frame (inclusive)
//               addr, chan     - current read address / channel
//               frame_done     - one-cycle pulse, registered with the wrap
// Revision    : 1.0 - initial release
// ============================================================================
module readout_addr_counter #(
  parameter int NCH = 4,
  parameter int AW  = 12,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          advance,
  input  logic          round_robin,
  input  logic [CW-1:0] load_chan,
  input  logic [CW-1:0] home_chan,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] chan,
  output logic          frame_done
);

  localparam logic [CW-1:0] LAST_CHAN = CW'(NCH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      chan       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        addr <= '0;
        chan <= '0;
      end else if (load) begin
        addr <= '0;
        chan <= load_chan;
      end else if (advance) begin
        if (round_robin && (chan < LAST_CHAN)) begin
          chan <= chan + CW'(1);
        end else begin
          chan <= home_chan;
          // ">=" rather than "==" so a last_addr lowered below the current
          // address makes the next word the last one instead of running on.
          if (addr < last_addr) begin
            addr <= addr + AW'(1);
          end else begin
            addr       <= '0;
            frame_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : readout_sequencer
// Description : Sequences reads out of NCH channel buffers while an SPI
//               readout transaction is open. Single-channel mode walks one
//               channel's addresses; round-robin mode reads every channel at
//               each address. Registers the selected word for the SPI
//               shifter and pulses frame_done when the address wraps.
// Ports       : sysclk        - clock (rising edge)
//               rst           - synchronous active-high reset
//               SPI_SS        - slave select, active low (low = transaction)
//               SPI_done      - one-cycle pulse, current word consumed
//               ZYNQ_word_num - last address per channel (inclusive)
//               mode          - 0 single-channel, 1 round-robin
//               chan_sel      - channel used in single-channel mode
//               ch_data       - flattened buffer outputs, channel k at k*DW
//               read_address  - address to all channel buffers
//               read_channel  - channel currently addressed
//               data_out      - registered selected word
//               data_valid    - data_out matches current address/channel
//               frame_done    - one-cycle pulse at frame completion
// Revision    : 1.0 - initial release
// ============================================================================
module readout_sequencer
  import readout_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int AW  = 12,
  parameter  int DW  = 16,
  localparam int CW  = chan_width(NCH)
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              SPI_SS,
  input  logic              SPI_done,
  input  logic [AW-1:0]     ZYNQ_word_num,
  input  logic              mode,
  input  logic [CW-1:0]     chan_sel,
  input  logic [NCH*DW-1:0] ch_data,
  output logic [AW-1:0]     read_address,
  output logic [CW-1:0]     read_channel,
  output logic [DW-1:0]     data_out,
  output logic              data_valid,
  output logic              frame_done
);

  // With a single buffer there is nothing to select or rotate through.
  localparam bit MULTI = (NCH > 1);

  state_t          state;
  state_t          state_next;
  logic            mode_q;
  logic [CW-1:0]   sel_q;
  logic            cnt_load;
  logic            cnt_clear;
  logic            cnt_advance;
  logic            round_robin;
  logic [CW-1:0]   load_chan;
  logic [CW-1:0]   home_chan;
  logic [DW-1:0]   word_sel;

  // --------------------------------------------------------------------------
  // Transaction FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_load    = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    unique case (state)
      IDLE: begin
        if (!SPI_SS) begin
          state_next = ACTIVE;
          cnt_load   = 1'b1;
        end else begin
          cnt_clear  = 1'b1;
        end
      end
      ACTIVE: begin
        // Slave select closing wins over a coincident SPI_done.
        if (SPI_SS) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else begin
          cnt_advance = SPI_done;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  // Mode and channel are frozen for the whole transaction so host-side
  // register writes cannot disturb a readout in progress.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      mode_q <= MODE_SINGLE;
      sel_q  <= '0;
    end else if (cnt_load) begin
      mode_q <= mode;
      sel_q  <= chan_sel;
    end
  end

  // The load edge is the same edge that latches mode/chan_sel, so the start
  // channel comes from the live inputs; later steps use the latched copies.
  assign load_chan   = (MULTI && (mode == MODE_SINGLE))   ? chan_sel : '0;
  assign home_chan   = (MULTI && (mode_q == MODE_SINGLE)) ? sel_q    : '0;
  assign round_robin = MULTI && (mode_q == MODE_RR);

  readout_addr_counter #(
    .NCH (NCH),
    .AW  (AW),
    .CW  (CW)
  ) u_addr_counter (
    .clk         (sysclk),
    .rst         (rst),
    .clear       (cnt_clear),
    .load        (cnt_load),
    .advance     (cnt_advance),
    .round_robin (round_robin),
    .load_chan   (load_chan),
    .home_chan   (home_chan),
    .last_addr   (ZYNQ_word_num),
    .addr        (read_address),
    .chan        (read_channel),
    .frame_done  (frame_done)
  );

  // --------------------------------------------------------------------------
  // Output word mux and register
  // --------------------------------------------------------------------------
  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (read_channel == CW'(k)) begin
        word_sel = ch_data[k*DW +: DW];
      end
    end
  end

  // A word consumed this cycle means the address moves, so next cycle's
  // data_out still belongs to the old address and is flagged not valid.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= (state == ACTIVE) && !SPI_done;
      if (state == ACTIVE) begin
        data_out <= word_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_readout_sequencer
// Description : Self-checking bench for readout_sequencer (NCH=4). Directed
//               scenarios followed by randomized traffic, all outputs compared
//               every cycle against a behavioural transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_readout_sequencer;

  localparam int NCH = 4;
  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int CW  = 2;

  logic              sysclk = 1'b0;
  logic              rst;
  logic              SPI_SS;
  logic              SPI_done;
  logic [AW-1:0]     ZYNQ_word_num;
  logic              mode;
  logic [CW-1:0]     chan_sel;
  logic [NCH*DW-1:0] ch_data;
  logic [AW-1:0]     read_address;
  logic [CW-1:0]     read_channel;
  logic [DW-1:0]     data_out;
  logic              data_valid;
  logic              frame_done;

  always #5 sysclk = ~sysclk;

  readout_sequencer #(
    .NCH (NCH),
    .AW  (AW),
    .DW  (DW)
  ) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .SPI_SS        (SPI_SS),
    .SPI_done      (SPI_done),
    .ZYNQ_word_num (ZYNQ_word_num),
    .mode          (mode),
    .chan_sel      (chan_sel),
    .ch_data       (ch_data),
    .read_address  (read_address),
    .read_channel  (read_channel),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .frame_done    (frame_done)
  );

  int n_total = 0;
  int n_bad   = 0;
  int fd_count = 0;

  // Behavioural model: transaction open flag, latched settings, position.
  bit          m_active = 1'b0;
  bit          m_mode   = 1'b0;
  int          m_sel    = 0;
  int          m_addr   = 0;
  int          m_ch     = 0;
  logic [DW-1:0] m_dout = '0;
  bit          m_valid  = 1'b0;
  bit          m_fd     = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int k);
    return ch_data[k*DW +: DW];
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_tick();
    logic [DW-1:0] nd;
    bit            nv;
    if (rst) begin
      m_active = 0; m_mode = 0; m_sel = 0; m_addr = 0; m_ch = 0;
      m_dout = '0; m_valid = 0; m_fd = 0;
      return;
    end
    nd   = m_active ? word_of(m_ch) : m_dout;
    nv   = m_active && !SPI_done;
    m_fd = 0;
    if (!m_active) begin
      m_addr = 0;
      m_ch   = 0;
      if (!SPI_SS) begin
        m_active = 1;
        m_mode   = mode;
        m_sel    = int'(chan_sel);
        m_ch     = mode ? 0 : int'(chan_sel);
      end
    end else if (SPI_SS) begin
      m_active = 0;
      m_addr   = 0;
      m_ch     = 0;
    end else if (SPI_done) begin
      if (m_mode && m_ch < NCH - 1) begin
        m_ch++;
      end else begin
        m_ch = m_mode ? 0 : m_sel;
        if (m_addr < int'(ZYNQ_word_num)) m_addr++;
        else begin
          m_addr = 0;
          m_fd   = 1;
        end
      end
    end
    m_dout  = nd;
    m_valid = nv;
  endtask

  task automatic step();
    model_tick();
    @(posedge sysclk);
    #1;
    check_eq("addr",  read_address, m_addr);
    check_eq("chan",  read_channel, m_ch);
    check_eq("dout",  data_out,     m_dout);
    check_eq("valid", data_valid,   m_valid);
    check_eq("fdone", frame_done,   m_fd);
    if (frame_done) fd_count++;
  endtask

  task automatic pulse_done();
    SPI_done = 1'b1;
    step();
    SPI_done = 1'b0;
  endtask

  int            exp33[5]    = '{1, 2, 3, 0, 1};
  int            exp34_ch[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int            exp34_ad[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  logic [DW-1:0] exp35[4];

  initial begin
    rst = 1'b1; SPI_SS = 1'b1; SPI_done = 1'b0; mode = 1'b0;
    chan_sel = '0; ZYNQ_word_num = '0; ch_data = '0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_addr",  read_address, 0);
    check_eq("rst_valid", data_valid,   0);
    step();

    // Single channel 2, last address 3.
    mode = 1'b0; chan_sel = 2'd2; ZYNQ_word_num = 12'd3; SPI_SS = 1'b0;
    step();
    check_eq("s1_start_ch", read_channel, 2);
    fd_count = 0;
    for (int i = 0; i < 5; i++) begin
      pulse_done();
      check_eq("s1_addr", read_address, exp33[i]);
      check_eq("s1_ch",   read_channel, 2);
      check_eq("s1_fd",   frame_done,   (i == 3));
      step();
    end
    check_eq("s1_fd_count", fd_count, 1);

    // Round-robin, last address 1, back-to-back consumes.
    SPI_SS = 1'b1; step();
    mode = 1'b1; ZYNQ_word_num = 12'd1; SPI_SS = 1'b0;
    step();
    fd_count = 0;
    for (int i = 0; i < 8; i++) begin
      pulse_done();
      check_eq("s2_ch",   read_channel, exp34_ch[i]);
      check_eq("s2_addr", read_address, exp34_ad[i]);
    end
    step();
    check_eq("s2_fd_count", fd_count, 1);

    // Data path in round-robin.
    SPI_SS = 1'b1; step();
    ch_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    exp35   = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    mode = 1'b1; ZYNQ_word_num = 12'd0; SPI_SS = 1'b0;
    step();
    step();
    check_eq("s3_dout0",  data_out,   exp35[0]);
    check_eq("s3_valid0", data_valid, 1);
    for (int i = 1; i < 4; i++) begin
      pulse_done();
      check_eq("s3_valid_lo", data_valid, 0);
      step();
      check_eq("s3_dout",     data_out,   exp35[i]);
      check_eq("s3_valid_hi", data_valid, 1);
    end

    // Slave select closes together with a consume at address 5.
    SPI_SS = 1'b1; step();
    mode = 1'b0; chan_sel = 2'd0; ZYNQ_word_num = 12'd20; SPI_SS = 1'b0;
    step();
    repeat (5) pulse_done();
    check_eq("s4_addr5", read_address, 5);
    fd_count = 0;
    SPI_SS = 1'b1; SPI_done = 1'b1;
    step();
    SPI_done = 1'b0;
    check_eq("s4_addr0", read_address, 0);
    check_eq("s4_fd",    frame_done,   0);
    pulse_done();
    check_eq("s4_idle_addr", read_address, 0);
    check_eq("s4_idle_ch",   read_channel, 0);
    check_eq("s4_fd_count",  fd_count,     0);

    // Reset mid-transaction at address 7, channel 3.
    mode = 1'b1; SPI_SS = 1'b0;
    step();
    repeat (31) pulse_done();
    check_eq("s5_addr7", read_address, 7);
    check_eq("s5_ch3",   read_channel, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("s5_rst_addr",  read_address, 0);
    check_eq("s5_rst_ch",    read_channel, 0);
    check_eq("s5_rst_dout",  data_out,     0);
    check_eq("s5_rst_valid", data_valid,   0);
    check_eq("s5_rst_fd",    frame_done,   0);

    // Settings changed mid-transaction are ignored until the next open.
    SPI_SS = 1'b1; step();
    mode = 1'b0; chan_sel = 2'd1; SPI_SS = 1'b0;
    step();
    mode = 1'b1; chan_sel = 2'd3;
    repeat (3) pulse_done();
    check_eq("s6_ch_held", read_channel, 1);
    check_eq("s6_addr",    read_address, 3);
    SPI_SS = 1'b1; step();
    SPI_SS = 1'b0; step();
    check_eq("s6_new_mode_ch", read_channel, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 39) == 0) SPI_SS = ~SPI_SS;
      SPI_done = ($urandom_range(0, 2) == 0);
      mode     = 1'($urandom_range(0, 1));
      chan_sel = CW'($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 15) == 0) ZYNQ_word_num = AW'($urandom_range(0, 6));
      ch_data  = {$urandom(), $urandom()};
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
